// File: rtl/tri_buf_pkg.sv
// Shared definitions for the triple-buffer rotation controller: select codes,
// swap kinds and the three ownership-rotation mappings on the select code.
package tri_buf_pkg;

    // Select code = (A owner, B owner); D is whichever buffer is left over.
    localparam logic [2:0] SEL_XY = 3'd0;
    localparam logic [2:0] SEL_XZ = 3'd1;
    localparam logic [2:0] SEL_YX = 3'd2;
    localparam logic [2:0] SEL_YZ = 3'd3;
    localparam logic [2:0] SEL_ZX = 3'd4;
    localparam logic [2:0] SEL_ZY = 3'd5;

    // Kind of ownership change applied on a clock edge.
    typedef enum logic [1:0] {
        SWAP_NONE = 2'd0,
        SWAP_W    = 2'd1,
        SWAP_R    = 2'd2,
        SWAP_WR   = 2'd3
    } swap_e;

    // Writer swap: A and D exchange buffers, B keeps its buffer.
    function automatic logic [2:0] next_sel_w(input logic [2:0] sel);
        case (sel)
            SEL_XY:  return SEL_ZY;
            SEL_XZ:  return SEL_YZ;
            SEL_YX:  return SEL_ZX;
            SEL_YZ:  return SEL_XZ;
            SEL_ZX:  return SEL_YX;
            SEL_ZY:  return SEL_XY;
            default: return sel;
        endcase
    endfunction

    // Reader swap: B and D exchange buffers, A keeps its buffer.
    function automatic logic [2:0] next_sel_r(input logic [2:0] sel);
        case (sel)
            SEL_XY:  return SEL_XZ;
            SEL_XZ:  return SEL_XY;
            SEL_YX:  return SEL_YZ;
            SEL_YZ:  return SEL_YX;
            SEL_ZX:  return SEL_ZY;
            SEL_ZY:  return SEL_ZX;
            default: return sel;
        endcase
    endfunction

    // Combined: B takes A's buffer, A takes D's, D takes B's old buffer.
    function automatic logic [2:0] next_sel_wr(input logic [2:0] sel);
        case (sel)
            SEL_XY:  return SEL_ZX;
            SEL_XZ:  return SEL_YX;
            SEL_YX:  return SEL_ZY;
            SEL_YZ:  return SEL_XY;
            SEL_ZX:  return SEL_YZ;
            SEL_ZY:  return SEL_XZ;
            default: return sel;
        endcase
    endfunction

endpackage

// File: rtl/tri_buf_ctrl_sel_next.sv
// tri_sel_next: combinational next-select lookup for a given swap kind.
// Illegal select codes pass through unchanged; the controller overrides them.
module tri_sel_next
    import tri_buf_pkg::*;
(
    input  logic [2:0] sel,
    input  swap_e      swap,
    output logic [2:0] sel_next
);

    // Pick the rotation mapping that matches the requested swap kind.
    always_comb begin
        sel_next = sel;
        case (swap)
            SWAP_W:  sel_next = next_sel_w(sel);
            SWAP_R:  sel_next = next_sel_r(sel);
            SWAP_WR: sel_next = next_sel_wr(sel);
            default: sel_next = sel;
        endcase
    end

endmodule

// File: rtl/tri_buf_ctrl.sv
// tri_buf_ctrl: triple-buffer ownership rotation controller.
// Produces the 3-bit buffer select for the mux stage, the fresh-frame flag and
// one-cycle swap pulses. Optional dropped-frame counter: TRI_BUF_DROP_CNT_EN.
module tri_buf_ctrl
    import tri_buf_pkg::*;
#(
    parameter logic [2:0] SEL_RESET = 3'b000
`ifdef TRI_BUF_DROP_CNT_EN
    ,
    parameter int DROP_CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done_a,
    input  logic       frame_done_b,
    input  logic       ready_c,
    input  logic       ready_t,
    output logic [2:0] select,
    output logic       fresh,
    output logic       swap_w,
    output logic       swap_r
`ifdef TRI_BUF_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    logic       pending_w;
    logic       pending_r;
    logic       pw;
    logic       pr;
    swap_e      swap_kind;
    logic [2:0] sel_rot;
    logic [2:0] select_n;
    logic       fresh_n;
    logic       swap_w_n;
    logic       swap_r_n;
    logic       pending_w_n;
    logic       pending_r_n;
    logic       drop_inc;

    tri_sel_next u_sel_next (
        .sel      (select),
        .swap     (swap_kind),
        .sel_next (sel_rot)
    );

    // Decide which event is served this cycle; combined beats writer beats reader.
    always_comb begin
        pw          = pending_w | frame_done_a;
        pr          = pending_r | frame_done_b;
        swap_kind   = SWAP_NONE;
        fresh_n     = fresh;
        swap_w_n    = 1'b0;
        swap_r_n    = 1'b0;
        pending_w_n = pw;
        pending_r_n = pr;
        drop_inc    = 1'b0;

        if (pw && pr && ready_c && ready_t) begin
            swap_kind   = SWAP_WR;
            fresh_n     = 1'b0;
            swap_w_n    = 1'b1;
            swap_r_n    = 1'b1;
            pending_w_n = 1'b0;
            pending_r_n = 1'b0;
        end else if (pw && ready_c) begin
            // An unread frame sitting in D is overwritten when fresh is already set.
            swap_kind   = SWAP_W;
            fresh_n     = 1'b1;
            swap_w_n    = 1'b1;
            pending_w_n = 1'b0;
            drop_inc    = fresh;
        end else if (pr && ready_t) begin
            // With nothing fresh in D the reader simply re-reads its own buffer.
            pending_r_n = 1'b0;
            if (fresh) begin
                swap_kind = SWAP_R;
                fresh_n   = 1'b0;
                swap_r_n  = 1'b1;
            end
        end

        // Codes 6/7 can only appear through upset; recover to the reset code.
        select_n = (select > SEL_ZY) ? SEL_RESET : sel_rot;
    end

    // Ownership state, pending events and swap pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select    <= SEL_RESET;
            fresh     <= 1'b0;
            swap_w    <= 1'b0;
            swap_r    <= 1'b0;
            pending_w <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            select    <= select_n;
            fresh     <= fresh_n;
            swap_w    <= swap_w_n;
            swap_r    <= swap_r_n;
            pending_w <= pending_w_n;
            pending_r <= pending_r_n;
        end
    end

`ifdef TRI_BUF_DROP_CNT_EN
    // Saturating count of frames overwritten before the reader picked them up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_inc;
`endif

endmodule

// File: tb/tb_tri_buf_ctrl.sv
// Testbench for tri_buf_ctrl: vector table, hand-written corner sequences and
// randomized traffic against an ownership-level reference model.
module tb_tri_buf_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_done_a;
    logic       frame_done_b;
    logic       ready_c;
    logic       ready_t;
    logic [2:0] select;
    logic       fresh;
    logic       swap_w;
    logic       swap_r;
`ifdef TRI_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tri_buf_ctrl #(.SEL_RESET(3'b000)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_done_a (frame_done_a),
        .frame_done_b (frame_done_b),
        .ready_c      (ready_c),
        .ready_t      (ready_t),
        .select       (select),
        .fresh        (fresh),
        .swap_w       (swap_w),
        .swap_r       (swap_r)
`ifdef TRI_BUF_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: physical buffer owned by A, B and D (0=X, 1=Y, 2=Z).
    int m_a, m_b, m_d, m_drop;
    bit m_fresh, m_pw, m_pr, m_sw, m_sr;

    function automatic int m_sel();
        return m_a * 2 + ((m_b > m_a) ? m_b - 1 : m_b);
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 1; m_d = 2;
        m_fresh = 0; m_pw = 0; m_pr = 0; m_sw = 0; m_sr = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit fa, input bit fb, input bit rc, input bit rt);
        bit pw, pr;
        int t;
        pw = m_pw | fa;
        pr = m_pr | fb;
        m_sw = 0;
        m_sr = 0;
        if (pw && pr && rc && rt) begin
            t = m_b; m_b = m_a; m_a = m_d; m_d = t;
            m_fresh = 0; m_sw = 1; m_sr = 1; m_pw = 0; m_pr = 0;
        end else if (pw && rc) begin
            if (m_fresh && m_drop < 65535) m_drop++;
            t = m_a; m_a = m_d; m_d = t;
            m_fresh = 1; m_sw = 1; m_pw = 0; m_pr = pr;
        end else if (pr && rt) begin
            if (m_fresh) begin
                t = m_b; m_b = m_d; m_d = t;
                m_fresh = 0; m_sr = 1;
            end
            m_pr = 0; m_pw = pw;
        end else begin
            m_pw = pw; m_pr = pr;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: apply inputs, advance model on the edge, settle 1 time unit.
    task automatic cycle(input bit fa, input bit fb, input bit rc, input bit rt);
        frame_done_a = fa; frame_done_b = fb; ready_c = rc; ready_t = rt;
        @(posedge clk);
        model_step(fa, fb, rc, rt);
        #1;
    endtask

    task automatic do_reset();
        frame_done_a = 0; frame_done_b = 0; ready_c = 0; ready_t = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit fa, fb, rc, rt;
        int sel;
        bit fr, sw, sr;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1; frame_done_a = 0; frame_done_b = 0; ready_c = 0; ready_t = 0;
        model_reset();
        #2;
        chk("reset_select", int'(select), 0);
        chk("reset_fresh", int'(fresh), 0);
        chk("reset_swap_w", int'(swap_w), 0);
        chk("reset_swap_r", int'(swap_r), 0);
        do_reset();

        //            fa fb rc rt  sel fr sw sr
        vecs.push_back('{1, 0, 1, 0, 5, 1, 1, 0});  // writer swap 0->5
        vecs.push_back('{0, 0, 0, 0, 5, 1, 0, 0});  // hold, pulse gone
        vecs.push_back('{0, 1, 0, 1, 4, 0, 0, 1});  // reader takes fresh 5->4
        vecs.push_back('{0, 1, 0, 1, 4, 0, 0, 0});  // nothing fresh: re-read
        vecs.push_back('{0, 0, 1, 1, 4, 0, 0, 0});  // ready without events
        vecs.push_back('{1, 1, 1, 1, 3, 0, 1, 1});  // combined 4->3
        vecs.push_back('{1, 0, 1, 0, 1, 1, 1, 0});  // writer 3->1
        vecs.push_back('{1, 0, 0, 0, 1, 1, 0, 0});  // writer pending
        vecs.push_back('{0, 0, 1, 0, 3, 1, 1, 0});  // pending fires 1->3
        vecs.push_back('{0, 1, 0, 0, 3, 1, 0, 0});  // reader pending
        vecs.push_back('{0, 0, 0, 1, 2, 0, 0, 1});  // reader fires 3->2
        vecs.push_back('{1, 0, 0, 0, 2, 0, 0, 0});  // first done, held
        vecs.push_back('{1, 0, 0, 0, 2, 0, 0, 0});  // repeat done merges
        vecs.push_back('{0, 0, 1, 0, 4, 1, 1, 0});  // single swap 2->4
        vecs.push_back('{0, 0, 1, 0, 4, 1, 0, 0});  // no double swap
        vecs.push_back('{1, 1, 1, 0, 2, 1, 1, 0});  // writer wins, reader kept 4->2
        vecs.push_back('{0, 0, 0, 1, 3, 0, 0, 1});  // kept reader fires 2->3

        foreach (vecs[i]) begin
            cycle(vecs[i].fa, vecs[i].fb, vecs[i].rc, vecs[i].rt);
            chk($sformatf("vec%0d_select", i), int'(select), vecs[i].sel);
            chk($sformatf("vec%0d_fresh", i), int'(fresh), int'(vecs[i].fr));
            chk($sformatf("vec%0d_swap_w", i), int'(swap_w), int'(vecs[i].sw));
            chk($sformatf("vec%0d_swap_r", i), int'(swap_r), int'(vecs[i].sr));
        end

        // Combined event straight from reset: 0->4, both pulses.
        do_reset();
        cycle(1, 1, 1, 1);
        chk("comb_select", int'(select), 4);
        chk("comb_fresh", int'(fresh), 0);
        chk("comb_swap_w", int'(swap_w), 1);
        chk("comb_swap_r", int'(swap_r), 1);

        // Writer held off by ready_c for 5 cycles, swap 1 cycle after ready rises.
        do_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            chk($sformatf("held%0d_select", i), int'(select), 0);
            chk($sformatf("held%0d_swap_w", i), int'(swap_w), 0);
        end
        cycle(0, 0, 1, 0);
        chk("held_release_select", int'(select), 5);
        chk("held_release_swap_w", int'(swap_w), 1);
        chk("held_release_fresh", int'(fresh), 1);

        // Reset while a writer event is pending: immediate clear, no swap after.
        do_reset();
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        rst = 1;
        #2;
        chk("midrst_select", int'(select), 0);
        chk("midrst_fresh", int'(fresh), 0);
        frame_done_a = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1);
            chk($sformatf("postrst%0d_select", i), int'(select), 0);
            chk($sformatf("postrst%0d_swap_w", i), int'(swap_w), 0);
        end

`ifdef TRI_BUF_DROP_CNT_EN
        // Three writer frames with no reader: two overwrites.
        do_reset();
        chk("drop_reset", int'(drop_cnt), 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        chk("drop_three_cnt", int'(drop_cnt), 2);
        chk("drop_three_select", int'(select), 5);
        cycle(1, 1, 1, 1);
        chk("drop_comb_nocount", int'(drop_cnt), 2);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit fa, fb, rc, rt;
            fa = ($urandom_range(0, 3) == 0);
            fb = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 2) != 0);
            rt = ($urandom_range(0, 2) != 0);
            cycle(fa, fb, rc, rt);
            chk("rand_select", int'(select), m_sel());
            chk("rand_fresh", int'(fresh), int'(m_fresh));
            chk("rand_swap_w", int'(swap_w), int'(m_sw));
            chk("rand_swap_r", int'(swap_r), int'(m_sr));
`ifdef TRI_BUF_DROP_CNT_EN
            chk("rand_drop_cnt", int'(drop_cnt), m_drop);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tri_buf_ctrl.md
Name: tri_buf_ctrl

Overview:
- Sequential rotation controller that generates the 3-bit select consumed by tri_mem_mux, tri_data_mux and tri_ready_mux.
- Tracks which of the physical buffers X/Y/Z is owned by the capture side (A), the transmit side (B) and the idle slot (D).
- Swaps ownership on frame-completion events, giving classic triple-buffer semantics: the writer never stalls and the reader always gets the newest complete frame.
- Sits directly upstream of the mux stage, fed by the capture and transmit modules' end-of-frame pulses and the muxed ready lines.

Parameters:
- SEL_RESET, 3'b000, select value after reset; must be 0..5.
- DROP_CNT_W, 16, width of the dropped-frame counter (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_done_a  in  1  1-cycle pulse: capture finished writing a full frame
- frame_done_b  in  1  1-cycle pulse: transmit finished reading a full frame
- ready_c  in  1  capture-side memory controller idle (from tri_ready_mux)
- ready_t  in  1  transmit-side memory controller idle (from tri_ready_mux)
- select  out  3  buffer routing code, always 0..5
- fresh  out  1  idle buffer holds a complete, unread frame
- swap_w  out  1  1-cycle pulse: A<->D ownership changed
- swap_r  out  1  1-cycle pulse: B ownership changed

Behaviour:
- Select encoding (A,B owner; D is the remaining buffer): 0=X,Y  1=X,Z  2=Y,X  3=Y,Z  4=Z,X  5=Z,Y.
- Reset: select=SEL_RESET, fresh=0, swap_w=0, swap_r=0, pending_w=0, pending_r=0. Reset is honoured mid-operation; all pending events are discarded.
- Each cycle: pw = pending_w | frame_done_a; pr = pending_r | frame_done_b. Evaluate the cases in priority order; exactly one applies.
- C1, combined (pw & pr & ready_c & ready_t):
  - B takes A's buffer, A takes D's buffer, D takes B's old buffer.
  - Select map: 0->4, 1->2, 2->5, 3->0, 4->3, 5->1.
  - fresh<=0; swap_w=swap_r=1; both pendings cleared.
- C2, writer swap (pw & ready_c, not C1):
  - A<->D. Select map: 0->5, 1->3, 2->4, 3->1, 4->2, 5->0.
  - fresh<=1; swap_w=1; pending_w cleared; pending_r<=pr.
- C3, reader request (pr & ready_t, not C1/C2):
  - If fresh: B<->D, select map 0->1, 1->0, 2->3, 3->2, 4->5, 5->4; fresh<=0; swap_r=1.
  - If !fresh: select unchanged (reader re-reads its buffer); swap_r=0.
  - pending_r cleared; pending_w<=pw.
- Otherwise: pending_w<=pw, pending_r<=pr; select and fresh hold.
- Latency: select, fresh and the swap pulses are registered and change on the clock edge after the qualifying cycle. A done pulse arriving with ready already high takes effect in 1 cycle.
- A repeated done pulse while its event is already pending merges into that event; no double swap.
- Illegal select values 6/7 are never produced. If one is ever present, the next state is SEL_RESET.

Optional Feature:
- Macro: TRI_BUF_DROP_CNT_EN.
- With it defined:
  - Adds output drop_cnt [DROP_CNT_W-1:0], reset 0.
  - Increments on C2 when fresh was already 1 (an unread frame was overwritten).
  - Saturates at all-ones.
  - C1 does not count.
- Without it: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package tri_buf_pkg: select code localparams (SEL_XY..SEL_ZY) and the three next-select mapping functions (writer, reader, combined).
- One combinational sub-module, tri_sel_next: takes select and a 2-bit swap type, returns the next select.
- The FSM, pending flags and counter live in tri_buf_ctrl.

Test Plan:
- Reset with SEL_RESET=0, then frame_done_a with ready_c=1 -> next cycle select=5, fresh=1, swap_w=1 for one cycle.
- From select=5, fresh=1: frame_done_b with ready_t=1 -> select=4, fresh=0, swap_r=1. A second frame_done_b -> select stays 4, swap_r=0.
- From select=0: frame_done_a and frame_done_b in the same cycle, both ready=1 -> select=4, fresh=0, both pulses high.
- frame_done_a with ready_c=0 for 5 cycles, then ready_c=1 -> no change while held; swap applied 1 cycle after ready rises (select 0->5).
- With TRI_BUF_DROP_CNT_EN: three frame_done_a with no reader events, from reset -> drop_cnt=2, select back to 5 after 0->5->0->5.
- Assert rst mid-pending (pending_w=1) -> select=SEL_RESET and fresh=0 immediately; no swap after release.
